// File: rtl/mips_mc_ctrl_pkg.sv
// Shared MIPS multicycle definitions: FSM state encodings, opcode/funct
// constants, ALU function codes and the ALU-decode selector.
// Ports: none (package); imported by the controller, its decoder and ALU tests.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // What the ALU decoder should produce this cycle.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // bit2=1 with bit3=0 routes through the logic unit.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: is_known_op = 1'b1;
      default:                        is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// strobes/selects/alucontrol/debug state out.
// Ports: master = controller side, slave = datapath side.
interface mips_mc_ctrl_if #(
  parameter int ALUW = 4
);
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            zero;
  logic [ALUW-1:0] alucontrol;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic            iord;
  logic            irwrite;
  logic            memwrite;
  logic            regwrite;
  logic            regdst;
  logic            memtoreg;
  logic [1:0]      pcsrc;
  logic            pcen;
  logic            illegal;
  logic [3:0]      state;

  modport master (
    input  op, funct, zero,
    output alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regwrite,
           regdst, memtoreg, pcsrc, pcen, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regwrite,
           regdst, memtoreg, pcsrc, pcen, illegal, state
  );
endinterface

// File: rtl/mips_mc_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's aluop request plus op/funct to an ALU code.
// Ports: aluop, op, funct in; alucontrol (ALUW bits), illegal out.
// Purely combinational; illegal flags an unsupported funct/immediate op.
module alu_dec
  import mips_pkg::*;
#(
  parameter int ALUW = 4
) (
  input  aluop_t          aluop,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  output logic [ALUW-1:0] alucontrol,
  output logic            illegal
);

  logic [3:0] code;

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_IMM: begin
        case (op)
          OP_ADDI: code = ALU_ADD;
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_SLTI: code = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUW'(code);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback.
// Ports: clk, reset_n (async active-low), bus (mips_mc_ctrl_if.master).
// Outputs are state-decoded except pcen (branch qualified by zero) and illegal.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUW = 4
) (
  input logic            clk,
  input logic            reset_n,
  mips_mc_ctrl_if.master bus
);

  state_t          state_q;
  state_t          state_d;
  aluop_t          aluop;
  logic            dec_illegal;
  logic [ALUW-1:0] dec_alucontrol;

  logic       alusrca, iord, irwrite, memwrite, regwrite, regdst, memtoreg;
  logic       pcen, illegal;
  logic [1:0] alusrcb, pcsrc;

  alu_dec #(.ALUW(ALUW)) u_alu_dec (
    .aluop      (aluop),
    .op         (bus.op),
    .funct      (bus.funct),
    .alucontrol (dec_alucontrol),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_RTYPEEX;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = dec_illegal ? S_FETCH : S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;  // writeback/branch/jump and unused codes
    endcase
  end

  always_comb begin
    aluop    = ALUOP_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcen    = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;  // precompute branch target into ALUOut
        illegal = !is_known_op(bus.op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        illegal = dec_illegal;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_IMM;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // The state register already sits in FETCH during reset; mask its
    // side-effecting strobes until reset is released.
    if (!reset_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign bus.alucontrol = dec_alucontrol;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.memwrite   = memwrite;
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.pcsrc      = pcsrc;
  assign bus.pcen       = pcen;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for the multicycle controller.
// Observed vector order: state, alucontrol, alusrca, alusrcb,
// iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcsrc, pcen, illegal.
module tb_mips_mc_ctrl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mips_mc_ctrl_if #(.ALUW(4)) bus ();

  mips_mc_ctrl #(.ALUW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb,
                bus.iord, bus.irwrite, bus.memwrite, bus.regwrite,
                bus.regdst, bus.memtoreg, bus.pcsrc, bus.pcen, bus.illegal};

  localparam logic [20:0] E_RST    = {4'd0,  4'b0000, 1'b0, 2'b01, 6'b000000, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_FETCH  = {4'd0,  4'b0000, 1'b0, 2'b01, 6'b010000, 2'b00, 1'b1, 1'b0};
  localparam logic [20:0] E_DECODE = {4'd1,  4'b0000, 1'b0, 2'b11, 6'b000000, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_DECILL = {4'd1,  4'b0000, 1'b0, 2'b11, 6'b000000, 2'b00, 1'b0, 1'b1};
  localparam logic [20:0] E_MEMADR = {4'd2,  4'b0000, 1'b1, 2'b10, 6'b000000, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_MEMRD  = {4'd3,  4'b0000, 1'b0, 2'b00, 6'b100000, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_MEMWB  = {4'd4,  4'b0000, 1'b0, 2'b00, 6'b000101, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_MEMWR  = {4'd5,  4'b0000, 1'b0, 2'b00, 6'b101000, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_RTYPEWB= {4'd7,  4'b0000, 1'b0, 2'b00, 6'b000110, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_IMMWB  = {4'd10, 4'b0000, 1'b0, 2'b00, 6'b000100, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_JUMP   = {4'd11, 4'b0000, 1'b0, 2'b00, 6'b000000, 2'b10, 1'b1, 1'b0};

  task automatic test_reset();
    reset_n  = 1'b0;
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;
    #3;
    if (obs !== E_RST) begin bad++; $display("FAIL reset_async obs=%h exp=%h", obs, E_RST); end
    total++;
    @(posedge clk); #1;
    if (obs !== E_RST) begin bad++; $display("FAIL reset_held obs=%h exp=%h", obs, E_RST); end
    total++;
    reset_n = 1'b1;
    @(negedge clk);
    if (obs !== E_FETCH) begin bad++; $display("FAIL reset_release_fetch obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_lw();
    bus.op = 6'b100011;
    if (obs !== E_FETCH)  begin bad++; $display("FAIL lw_fetch obs=%h exp=%h", obs, E_FETCH); end
    total++;
    @(negedge clk);
    if (obs !== E_DECODE) begin bad++; $display("FAIL lw_decode obs=%h exp=%h", obs, E_DECODE); end
    total++;
    @(negedge clk);
    if (obs !== E_MEMADR) begin bad++; $display("FAIL lw_memadr obs=%h exp=%h", obs, E_MEMADR); end
    total++;
    @(negedge clk);
    if (obs !== E_MEMRD)  begin bad++; $display("FAIL lw_memrd obs=%h exp=%h", obs, E_MEMRD); end
    total++;
    @(negedge clk);
    if (obs !== E_MEMWB)  begin bad++; $display("FAIL lw_memwb obs=%h exp=%h", obs, E_MEMWB); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH)  begin bad++; $display("FAIL lw_done obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_sw();
    bus.op = 6'b101011;
    @(negedge clk);
    if (obs !== E_DECODE) begin bad++; $display("FAIL sw_decode obs=%h exp=%h", obs, E_DECODE); end
    total++;
    @(negedge clk);
    if (obs !== E_MEMADR) begin bad++; $display("FAIL sw_memadr obs=%h exp=%h", obs, E_MEMADR); end
    total++;
    @(negedge clk);
    if (obs !== E_MEMWR)  begin bad++; $display("FAIL sw_memwr obs=%h exp=%h", obs, E_MEMWR); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH)  begin bad++; $display("FAIL sw_done obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [3:0] code);
    logic [20:0] e_ex;
    e_ex = {4'd6, code, 1'b1, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b0};
    bus.op    = 6'b000000;
    bus.funct = fn;
    @(negedge clk);
    if (obs !== E_DECODE)  begin bad++; $display("FAIL rtype_decode fn=%b obs=%h exp=%h", fn, obs, E_DECODE); end
    total++;
    @(negedge clk);
    if (obs !== e_ex)      begin bad++; $display("FAIL rtype_ex fn=%b obs=%h exp=%h", fn, obs, e_ex); end
    total++;
    @(negedge clk);
    if (obs !== E_RTYPEWB) begin bad++; $display("FAIL rtype_wb fn=%b obs=%h exp=%h", fn, obs, E_RTYPEWB); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH)   begin bad++; $display("FAIL rtype_done fn=%b obs=%h exp=%h", fn, obs, E_FETCH); end
    total++;
  endtask

  task automatic test_rtype_bad();
    logic [20:0] e_ex;
    e_ex = {4'd6, 4'b0000, 1'b1, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};
    bus.op    = 6'b000000;
    bus.funct = 6'b111111;
    @(negedge clk);
    @(negedge clk);
    if (obs !== e_ex)    begin bad++; $display("FAIL rtype_bad_ex obs=%h exp=%h", obs, e_ex); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH) begin bad++; $display("FAIL rtype_bad_next obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic z, input logic exp_pcen);
    logic [20:0] e_br;
    e_br = {4'd8, 4'b0001, 1'b1, 2'b00, 6'b000000, 2'b01, exp_pcen, 1'b0};
    bus.op   = opc;
    bus.zero = z;
    @(negedge clk);
    if (obs !== E_DECODE) begin bad++; $display("FAIL br_decode op=%b obs=%h exp=%h", opc, obs, E_DECODE); end
    total++;
    @(negedge clk);
    if (obs !== e_br)     begin bad++; $display("FAIL br_exec op=%b z=%b obs=%h exp=%h", opc, z, obs, e_br); end
    total++;
    // pcen follows zero combinationally inside BRANCH
    bus.zero = ~z;
    #1;
    if (bus.pcen !== ~exp_pcen) begin bad++; $display("FAIL br_zero_comb op=%b pcen=%b exp=%b", opc, bus.pcen, ~exp_pcen); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH)  begin bad++; $display("FAIL br_done op=%b obs=%h exp=%h", opc, obs, E_FETCH); end
    total++;
    bus.zero = 1'b0;
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic [3:0] code);
    logic [20:0] e_ex;
    e_ex = {4'd9, code, 1'b1, 2'b10, 6'b000000, 2'b00, 1'b0, 1'b0};
    bus.op = opc;
    @(negedge clk);
    @(negedge clk);
    if (obs !== e_ex)    begin bad++; $display("FAIL imm_ex op=%b obs=%h exp=%h", opc, obs, e_ex); end
    total++;
    @(negedge clk);
    if (obs !== E_IMMWB) begin bad++; $display("FAIL imm_wb op=%b obs=%h exp=%h", opc, obs, E_IMMWB); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH) begin bad++; $display("FAIL imm_done op=%b obs=%h exp=%h", opc, obs, E_FETCH); end
    total++;
  endtask

  task automatic test_jump();
    bus.op = 6'b000010;
    @(negedge clk);
    @(negedge clk);
    if (obs !== E_JUMP)  begin bad++; $display("FAIL jump_exec obs=%h exp=%h", obs, E_JUMP); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH) begin bad++; $display("FAIL jump_done obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_illegal();
    bus.op = 6'b111111;
    @(negedge clk);
    if (obs !== E_DECILL) begin bad++; $display("FAIL illegal_decode obs=%h exp=%h", obs, E_DECILL); end
    total++;
    @(negedge clk);
    if (obs !== E_FETCH)  begin bad++; $display("FAIL illegal_next obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b100011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    if (obs !== E_MEMRD) begin bad++; $display("FAIL midrst_memrd obs=%h exp=%h", obs, E_MEMRD); end
    total++;
    #2 reset_n = 1'b0;
    #1;
    if (obs !== E_RST) begin bad++; $display("FAIL midrst_async obs=%h exp=%h", obs, E_RST); end
    total++;
    @(posedge clk); #1;
    if (bus.regwrite !== 1'b0 || bus.state !== 4'd0) begin
      bad++; $display("FAIL midrst_held regwrite=%b state=%0d exp regwrite=0 state=0", bus.regwrite, bus.state);
    end
    total++;
    reset_n = 1'b1;
    @(negedge clk);
    if (obs !== E_FETCH) begin bad++; $display("FAIL midrst_release obs=%h exp=%h", obs, E_FETCH); end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype(6'b100010, 4'b0001);
    test_rtype(6'b100111, 4'b0111);
    test_rtype(6'b101010, 4'b0011);
    test_rtype(6'b100110, 4'b0110);
    test_rtype_bad();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_imm(6'b001101, 4'b0101);
    test_imm(6'b001000, 4'b0000);
    test_imm(6'b001100, 4'b0100);
    test_imm(6'b001010, 4'b0011);
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter ALUW, default 4, SHALL set the ALU function-code width driven to the alu block.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  instruction opcode field from the instruction register.
REQ-005 funct  in  6  R-type function field from the instruction register.
REQ-006 zero  in  1  alu zero flag (y == 0).
REQ-007 alucontrol  out  ALUW  alu function code.
REQ-008 alusrca  out  1  0=PC, 1=register A.
REQ-009 alusrcb  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 iord, irwrite, memwrite, regwrite, regdst, memtoreg  out  1 each  datapath strobes/selects.
REQ-011 pcsrc  out  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-012 pcen  out  1  PC write enable (unconditional OR qualified branch).
REQ-013 illegal  out  1  one-cycle pulse on undecodable opcode/funct.
REQ-014 state  out  4  current FSM state, for debug.

Function
REQ-015 alucontrol codes SHALL be: ADD 0000, SUB 0001, SLT 0011, AND 0100, OR 0101, XOR 0110, NOR 0111 (bit2=1 with bit3=0 selects the logic unit).
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCH, IMMEX, IMMWB, JUMP; all outputs Moore (state-decoded) except pcen.
REQ-017 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, ADD, pcsrc=00, pcen=1; next DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut); next by op: lw/sw(100011/101011)->MEMADR, R(000000)->RTYPEEX, beq/bne(000100/000101)->BRANCH, addi/andi/ori/slti(001000/001100/001101/001010)->IMMEX, j(000010)->JUMP, other->FETCH with illegal=1.
REQ-019 MEMADR: alusrca=1, alusrcb=10, ADD; lw->MEMRD, sw->MEMWR.
REQ-020 MEMRD: iord=1; next MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-021 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT; other funct -> illegal=1, next FETCH, else RTYPEWB.
REQ-023 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-024 BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01; pcen = zero for beq, ~zero for bne (combinational on zero); next FETCH.
REQ-025 IMMEX: alusrca=1, alusrcb=10; addi ADD, andi AND, ori OR, slti SLT; next IMMWB. IMMWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-026 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-027 Latency in cycles SHALL be: lw 5, sw 4, R 4, imm 4, beq/bne 3, j 3, illegal 2.
REQ-028 All strobes not listed for a state SHALL be 0; selects not listed SHALL be 0; alucontrol defaults to ADD.
REQ-029 op/funct SHALL be sampled only in DECODE, MEMADR, RTYPEEX, BRANCH, IMMEX (IR is stable after FETCH).
REQ-030 Unreachable state encodings SHALL return to FETCH next cycle with all strobes 0.

Reset
REQ-031 reset_n low SHALL force state=FETCH immediately, independent of clk, including mid-instruction.
REQ-032 While reset_n is low, pcen, irwrite, memwrite, regwrite and illegal SHALL be 0; FETCH strobes resume on the first rising edge after deassertion... first cycle after release is a full FETCH.

Structure
REQ-033 State encodings, opcode/funct constants and alucontrol codes SHALL live in shared package mips_pkg, also used by alu tests.
REQ-034 Sub-module alu_dec (combinational funct/op -> alucontrol, illegal) SHALL be instantiated; FSM stays in mips_mc_ctrl.

Verification
REQ-035 Reset mid-MEMRD of lw -> state=FETCH asynchronously, regwrite never asserts for that lw.
REQ-036 lw op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-037 R-type funct=100010 -> alucontrol=0001 in RTYPEEX, regdst=1 regwrite=1 next cycle; funct=100111 -> 0111.
REQ-038 beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; bne with zero=1 -> pcen=0.
REQ-039 op=111111 -> illegal=1 in DECODE for exactly one cycle, next state FETCH, no memwrite/regwrite.
REQ-040 ori op=001101 -> alucontrol=0101, alusrcb=10 in IMMEX; regwrite=1, regdst=0 in IMMWB.
